// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state type, default sizes and beat counter width for dmem_arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU, DMA} state_e;
  localparam int RAM_WORDS_DEF = 64;
  localparam int MAX_BURST_DEF = 8;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_arb_burst_cnt.sv
// dmem_arb_burst_cnt: burst base/length latch, beat counter and last-beat detect
module dmem_arb_burst_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             adv,
  input  logic [31:0]      addr_in,
  input  logic             we_in,
  input  logic [3:0]       len_in,
  output logic [31:0]      base,
  output logic             we,
  output logic [CNT_W-1:0] beat,
  output logic             last
);
  logic [31:0] base_q, base_d;
  logic we_q, we_d;
  logic [CNT_W-1:0] len_q, len_d, beat_q, beat_d;
  assign base = base_q;
  assign we = we_q;
  assign beat = beat_q;
  assign last = beat_q == len_q - 1'b1;
  always_comb begin
    base_d = base_q;
    we_d = we_q;
    len_d = len_q;
    beat_d = beat_q;
    if (load) begin
      base_d = addr_in;
      we_d = we_in;
      beat_d = '0;
      len_d = (len_in == '0) ? CNT_W'(1) : (32'(len_in) > MAX_BURST) ? CNT_W'(MAX_BURST) : CNT_W'(len_in);
    end else if (adv) begin
      beat_d = last ? '0 : beat_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      we_q <= 1'b0;
      len_q <= CNT_W'(1);
      beat_q <= '0;
    end else begin
      base_q <= base_d;
      we_q <= we_d;
      len_q <= len_d;
      beat_q <= beat_d;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA data RAM arbiter, burst-level round robin; DMEM_ARB_RANGE_CHECK_EN adds err output
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RAM_WORDS = RAM_WORDS_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);
  localparam int AW = $clog2(RAM_WORDS * 4);
  state_e state_q, state_d;
  logic last_dma_q, last_dma_d;
  logic in_dma, load, last, cpu_go, we_b, wr;
  logic [31:0] base, addr;
  logic [CNT_W-1:0] beat;
  logic [AW-1:0] off;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic bad;
`endif
  assign in_dma = state_q == DMA;
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;
  dmem_arb_burst_cnt #(.MAX_BURST(MAX_BURST)) u_cnt (
    .clk(clk), .reset(reset), .load(load), .adv(in_dma),
    .addr_in(dma_addr), .we_in(dma_we), .len_in(dma_len),
    .base(base), .we(we_b), .beat(beat), .last(last)
  );
  // CPU is always served outside a burst; the record only decides whether a pending DMA may start
  always_comb begin
    cpu_go = cpu_req & ~in_dma;
    load = ~in_dma & dma_req & ~(cpu_req & last_dma_q);
    state_d = in_dma ? (last ? IDLE : DMA) : load ? DMA : cpu_req ? CPU : IDLE;
    last_dma_d = (in_dma & last) | (last_dma_q & ~cpu_go);
    off = base[AW-1:0] + AW'({beat, 2'b00});
    addr = in_dma ? {base[31:AW], off} : cpu_req ? cpu_addr : '0;
    wr = in_dma ? we_b : cpu_req & cpu_we;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    bad = (in_dma | cpu_req) & ((addr[31:AW] != '0) | (addr[1:0] != 2'b00));
    mem_we = ~reset & wr & ~bad;
    err = ~reset & bad;
`else
    mem_we = ~reset & wr;
`endif
    mem_addr = reset ? '0 : addr;
    mem_wdata = reset ? '0 : in_dma ? dma_wdata : cpu_req ? cpu_wdata : '0;
    cpu_stall = ~reset & in_dma & cpu_req;
    dma_gnt = ~reset & in_dma;
    dma_done = ~reset & in_dma & last;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_dma_q <= 1'b1;
    end else begin
      state_q <= state_d;
      last_dma_q <= last_dma_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_dmem_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic cpu_req = 0, cpu_we = 0, cpu_stall;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic dma_req = 0, dma_we = 0, dma_gnt, dma_done;
  logic [31:0] dma_addr = 0, dma_wdata = 0, dma_rdata;
  logic [3:0] dma_len = 0;
  logic mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic err;
`endif
  logic [31:0] ram [64];
  logic [31:0] exp_ram [64];
  int n_chk = 0;
  int n_fail = 0;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_RANGE_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = ram[mem_addr[7:2]];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0;
  endtask

  task automatic cpu_fill(input int w, input logic [31:0] d);
    cpu_req = 1; cpu_we = 1; cpu_addr = w * 4; cpu_wdata = d;
    step;
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic test_reset;
    reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD;
    dma_req = 1; dma_we = 1; dma_len = 4; dma_addr = 32'h40; dma_wdata = 32'hBEEF;
    step; step;
    n_chk++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0h want 0", cpu_stall); end
    n_chk++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0h want 0", dma_gnt); end
    n_chk++; if (dma_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h want 0", dma_done); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h want 0", mem_we); end
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
    n_chk++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %0h want 0", mem_wdata); end
    idle_in;
    reset = 0;
    step;
  endtask

  task automatic test_cpu_write;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h1234;
    #1;
    n_chk++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_we: got %0h want 1", mem_we); end
    n_chk++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_stall: got %0h want 0", cpu_stall); end
    n_chk++; if (mem_addr !== 32'h8) begin n_fail++; $display("FAIL cpu_wr_addr: got %0h want 8", mem_addr); end
    step;
    cpu_we = 0;
    #1;
    n_chk++; if (cpu_rdata !== 32'h1234) begin n_fail++; $display("FAIL cpu_rd_data: got %0h want 1234", cpu_rdata); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_we: got %0h want 0", mem_we); end
    step;
    idle_in;
  endtask

  task automatic dma_burst(input string nm, input logic [31:0] a, input int len, input logic [31:0] d0);
    dma_req = 1; dma_we = 1; dma_addr = a; dma_len = 4'(len);
    #1;
    n_chk++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL %s_latch_gnt: got %0h want 0", nm, dma_gnt); end
    step;
    dma_req = 0; dma_addr = 32'h3C; dma_len = 1; dma_we = 0;
    for (int b = 0; b < len; b++) begin
      dma_wdata = d0 + b;
      #1;
      n_chk++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL %s_gnt beat %0d: got %0h want 1", nm, b, dma_gnt); end
      n_chk++; if (mem_addr !== ((a + 4 * b) & 32'hFF)) begin n_fail++; $display("FAIL %s_addr beat %0d: got %0h want %0h", nm, b, mem_addr, (a + 4 * b) & 32'hFF); end
      n_chk++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL %s_we beat %0d: got %0h want 1", nm, b, mem_we); end
      n_chk++; if (dma_done !== (b == len - 1)) begin n_fail++; $display("FAIL %s_done beat %0d: got %0h want %0h", nm, b, dma_done, b == len - 1); end
      step;
    end
    #1;
    n_chk++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL %s_after_gnt: got %0h want 0", nm, dma_gnt); end
  endtask

  task automatic test_dma_write;
    dma_burst("dma_wr", 32'h10, 4, 32'hA0);
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (ram[4 + k] !== 32'hA0 + k) begin n_fail++; $display("FAIL dma_wr_ram word %0d: got %0h want %0h", 4 + k, ram[4 + k], 32'hA0 + k); end
    end
  endtask

  task automatic test_wrap;
    dma_burst("wrap", 32'hF8, 3, 32'hB0);
    n_chk++; if (ram[62] !== 32'hB0) begin n_fail++; $display("FAIL wrap_w62: got %0h want b0", ram[62]); end
    n_chk++; if (ram[63] !== 32'hB1) begin n_fail++; $display("FAIL wrap_w63: got %0h want b1", ram[63]); end
    n_chk++; if (ram[0] !== 32'hB2) begin n_fail++; $display("FAIL wrap_w0: got %0h want b2", ram[0]); end
  endtask

  task automatic test_conflict;
    reset = 1; step; reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 0; dma_req = 1; dma_we = 0; dma_len = 2; dma_addr = 32'h80;
    #1;
    n_chk++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL conf_c0_stall: got %0h want 0", cpu_stall); end
    n_chk++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL conf_c0_gnt: got %0h want 0", dma_gnt); end
    step;
    #1;
    n_chk++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL conf_c1_stall: got %0h want 0", cpu_stall); end
    n_chk++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL conf_c1_gnt: got %0h want 0", dma_gnt); end
    step;
    dma_req = 0;
    #1;
    n_chk++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL conf_c2_gnt: got %0h want 1", dma_gnt); end
    n_chk++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL conf_c2_stall: got %0h want 1", cpu_stall); end
    step;
    #1;
    n_chk++; if (dma_done !== 1'b1) begin n_fail++; $display("FAIL conf_c3_done: got %0h want 1", dma_done); end
    step;
    dma_req = 1;
    #1;
    n_chk++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL conf_c4_stall: got %0h want 0", cpu_stall); end
    step;
    #1;
    n_chk++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL conf_c5_gnt (cpu priority): got %0h want 0", dma_gnt); end
    step;
    dma_req = 0;
    #1;
    n_chk++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL conf_c6_gnt: got %0h want 1", dma_gnt); end
    idle_in;
    for (int k = 0; k < 3; k++) step;
  endtask

  task automatic test_reset_mid;
    for (int w = 40; w < 45; w++) cpu_fill(w, 32'h55);
    dma_req = 1; dma_we = 1; dma_addr = 32'hA0; dma_len = 5;
    step;
    dma_req = 0;
    for (int b = 0; b < 2; b++) begin dma_wdata = 32'hD0 + b; step; end
    dma_wdata = 32'hD2; reset = 1;
    #1;
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we: got %0h want 0", mem_we); end
    n_chk++; if (dma_done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %0h want 0", dma_done); end
    n_chk++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt: got %0h want 0", dma_gnt); end
    step;
    reset = 0; cpu_req = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++; if (dma_gnt !== 1'b0 || dma_done !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_idle cyc %0d: gnt %0h done %0h stall %0h want 0 0 0", k, dma_gnt, dma_done, cpu_stall); end
      step;
    end
    idle_in;
    n_chk++; if (ram[40] !== 32'hD0 || ram[41] !== 32'hD1) begin n_fail++; $display("FAIL rmid_written: got %0h %0h want d0 d1", ram[40], ram[41]); end
    for (int w = 42; w < 45; w++) begin
      n_chk++; if (ram[w] !== 32'h55) begin n_fail++; $display("FAIL rmid_unwritten word %0d: got %0h want 55", w, ram[w]); end
    end
  endtask

  task automatic test_random;
    bit act = 0, b_we = 0, last_dma = 1;
    int beat = 0, b_len = 1, b_base = 0;
    logic e_stall, e_gnt, e_done, e_we;
    logic [31:0] e_addr, e_wd;
    for (int w = 0; w < 64; w++) begin cpu_fill(w, 32'hC0DE0000 | w); exp_ram[w] = 32'hC0DE0000 | w; end
    reset = 1; step; reset = 0;
    for (int i = 0; i < 420; i++) begin
      cpu_req = $urandom_range(0, 1); cpu_we = $urandom_range(0, 1);
      cpu_addr = $urandom_range(0, 63) * 4; cpu_wdata = $urandom;
      dma_req = ($urandom_range(0, 2) == 0); dma_we = $urandom_range(0, 1);
      dma_addr = $urandom_range(0, 63) * 4; dma_len = 4'($urandom_range(0, 15)); dma_wdata = $urandom;
      if (i >= 400) begin cpu_req = 0; dma_req = 0; end
      if (act) begin
        e_addr = 32'((b_base + 4 * beat) % 256); e_we = b_we; e_wd = dma_wdata;
        e_gnt = 1; e_done = (beat == b_len - 1); e_stall = cpu_req;
      end else begin
        e_addr = cpu_req ? cpu_addr : 0; e_we = cpu_req & cpu_we; e_wd = cpu_req ? cpu_wdata : 0;
        e_gnt = 0; e_done = 0; e_stall = 0;
      end
      #1;
      n_chk++; if (cpu_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d: got %0h want %0h", i, cpu_stall, e_stall); end
      n_chk++; if (dma_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc %0d: got %0h want %0h", i, dma_gnt, e_gnt); end
      n_chk++; if (dma_done !== e_done) begin n_fail++; $display("FAIL rnd_done cyc %0d: got %0h want %0h", i, dma_done, e_done); end
      n_chk++; if (mem_we !== e_we) begin n_fail++; $display("FAIL rnd_we cyc %0d: got %0h want %0h", i, mem_we, e_we); end
      n_chk++; if (mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr cyc %0d: got %0h want %0h", i, mem_addr, e_addr); end
      n_chk++; if (mem_wdata !== e_wd) begin n_fail++; $display("FAIL rnd_wdata cyc %0d: got %0h want %0h", i, mem_wdata, e_wd); end
      n_chk++; if (cpu_rdata !== exp_ram[e_addr[7:2]] || dma_rdata !== exp_ram[e_addr[7:2]]) begin n_fail++; $display("FAIL rnd_rdata cyc %0d: got %0h/%0h want %0h", i, cpu_rdata, dma_rdata, exp_ram[e_addr[7:2]]); end
`ifdef DMEM_ARB_RANGE_CHECK_EN
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_err cyc %0d: got %0h want 0", i, err); end
`endif
      if (e_we) exp_ram[e_addr[7:2]] = e_wd;
      if (act) begin
        if (beat == b_len - 1) begin act = 0; last_dma = 1; end else beat++;
      end else begin
        if (dma_req && !(cpu_req && last_dma)) begin
          act = 1; beat = 0; b_base = int'(dma_addr); b_we = dma_we;
          b_len = (dma_len == 0) ? 1 : (dma_len > 8) ? 8 : int'(dma_len);
        end
        if (cpu_req) last_dma = 0;
      end
      step;
    end
    idle_in;
    for (int w = 0; w < 64; w++) begin
      n_chk++; if (ram[w] !== exp_ram[w]) begin n_fail++; $display("FAIL rnd_ram word %0d: got %0h want %0h", w, ram[w], exp_ram[w]); end
    end
  endtask

`ifdef DMEM_ARB_RANGE_CHECK_EN
  task automatic test_range;
    logic [31:0] keep;
    keep = ram[0];
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'hFFFF;
    #1;
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err: got %0h want 1", err); end
    n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL range_we: got %0h want 0", mem_we); end
    step;
    idle_in;
    #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL range_err_idle: got %0h want 0", err); end
    n_chk++; if (ram[0] !== keep) begin n_fail++; $display("FAIL range_ram: got %0h want %0h", ram[0], keep); end
  endtask
`endif

  initial begin
    test_reset;
    test_cpu_write;
    test_dma_write;
    test_wrap;
    test_conflict;
    test_reset_mid;
    test_random;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    test_range;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be:
- RAM_WORDS, 64, data RAM depth in 32-bit words.
- MAX_BURST, 8, maximum DMA burst length in beats.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU memory access this cycle.
- cpu_we  in  1  CPU write.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_stall  out  1  CPU access not serviced this cycle.
- cpu_rdata  out  32  CPU read data.
- dma_req  in  1  DMA burst request.
- dma_we  in  1  DMA burst is a write.
- dma_addr  in  32  DMA burst start byte address.
- dma_len  in  4  DMA burst length (1..MAX_BURST).
- dma_wdata  in  32  DMA write data for the current beat.
- dma_gnt  out  1  DMA beat serviced this cycle.
- dma_done  out  1  pulse on the last DMA beat.
- dma_rdata  out  32  DMA read data.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  RAM byte address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data (combinational read).

Function
REQ-003 FSM states SHALL be IDLE, CPU, and DMA; each state serves one RAM access per cycle.
REQ-004 In IDLE/CPU, the arbiter SHALL route the CPU port to the RAM combinationally whenever cpu_req=1 and no DMA burst is active: cpu_stall=0, zero-cycle read latency.
REQ-005 On dma_req=1 in IDLE/CPU, the arbiter SHALL latch dma_addr, dma_we, and dma_len, and enter DMA on the next edge, except when the CPU has priority (REQ-007).
REQ-006 In DMA, each cycle SHALL:
- drive mem_addr = latched base + 4*beat.
- assert dma_gnt.
- assert mem_we = latched we.
- increment the beat count.
After beat dma_len-1, it SHALL assert dma_done and return to IDLE.
REQ-007 Round-robin at burst granularity: when cpu_req and dma_req are both 1, the requester not served last SHALL win; the winner record SHALL be updated after every completed CPU access and every completed DMA burst.
REQ-008 While in DMA, cpu_stall SHALL equal cpu_req; a CPU request SHALL NOT wait more than MAX_BURST cycles.
REQ-009 dma_len=0 SHALL be treated as 1; dma_len>MAX_BURST SHALL be clamped to MAX_BURST.
REQ-010 Burst addresses SHALL wrap modulo RAM_WORDS*4 (word 63 followed by word 0).
REQ-011 cpu_rdata and dma_rdata SHALL both present mem_rdata; mem_we SHALL be 0 whenever no port is granted.
REQ-012 Inputs on dma_* other than dma_wdata SHALL be ignored while a burst is active.

Reset
REQ-013 reset=1 at a clock edge SHALL:
- force IDLE.
- clear the beat counter.
- set the round-robin record to "DMA served last" (CPU wins the first conflict).
REQ-014 During reset, the arbiter SHALL drive: cpu_stall=0, dma_gnt=0, dma_done=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-015 Reset mid-burst SHALL abandon the burst with no further writes and no dma_done.

Configuration
REQ-016 Macro DMEM_ARB_RANGE_CHECK_EN SHALL control address range checking:
- Defined: add output err (1 bit). A granted access with word address >= RAM_WORDS, or a non-word-aligned address, SHALL suppress mem_we and assert err for that cycle; err SHALL be 0 on reset.
- Undefined: no err port, and addresses SHALL pass unchecked.

Structure
REQ-017 Package dmem_arb_pkg SHALL hold the FSM state enum, RAM_WORDS/MAX_BURST defaults, and the beat-count width constant.
REQ-018 Sub-module dmem_arb_burst_cnt SHALL hold the burst base/length latch, the beat counter, and last-beat detection.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- CPU-only write: cpu_we=1, addr 0x8, data 0x1234 -> mem_we=1 same cycle, cpu_stall=0; a read of 0x8 returns 0x1234.
- DMA-only write: dma_len=4, addr 0x10, data 0xA0..0xA3 -> dma_gnt for 4 cycles, RAM words 4..7 = 0xA0..0xA3, dma_done on cycle 4.
- Simultaneous request after reset: CPU served first (cpu_stall=0), DMA starts next cycle; the following conflict goes to DMA.
- Wrap: dma_len=3, addr 0xF8 -> writes words 62, 63, 0.
- Reset asserted on beat 2 of 5 -> words 2..4 of the burst unwritten, dma_done never asserted, IDLE after the edge.
- With DMEM_ARB_RANGE_CHECK_EN: CPU write to 0x100 -> err=1, mem_we=0, RAM unchanged.
